layer_sequencer: RTL
====================

# layer_sequencer

Sequencing controller for one fully-connected layer of the MNIST network. It walks the shared input-activation and weight ROM address through all `N_IN` inputs. It drives the common `Active` strobe of every neuron MAC in the layer, and gates operands so the accumulators clear and drain correctly. When all neuron `Z` outputs are final, it pulses `Done`. One instance sits beside each neuron bank (784→20, 20→20, 20→10), and the top-level FSM chains them.

## Interface
- `N_IN`, 784: number of inputs (MAC terms) per neuron; must be ≥ 1.
- `RD_LAT`, 1: cycles from `Addr` to matching X/W data at the neuron inputs.
- `MAC_LAT`, 2: cycles from an operand at the MAC input to its contribution appearing in the accumulator result.
- `CLR_CYC`, 2: minimum cycles `Active` is held low before a run, to clear the accumulators; must be ≥ 1.
- `AW`, `$clog2(N_IN)` (min 1): address width.

Ports:
- `Clk`  in  1  clock; all logic on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  run request; sampled only in IDLE.
- `Abort`  in  1  synchronous cancel; returns to IDLE next cycle with no `Done`.
- `Addr`  out  AW  shared read address for the X buffer and every neuron's W ROM.
- `Operand_valid`  out  1  high while real X/W data is at the neuron inputs; the top level forces X to 0 when low.
- `Active`  out  1  common neuron strobe; low clears the accumulators, high accumulates and updates `Z`.
- `Busy`  out  1  high from the cycle after Start acceptance through the `Done` cycle inclusive.
- `Done`  out  1  one-cycle pulse; all neuron `Z` values are final and stable until the next run.

## Operation
- States: IDLE, CLEAR, RUN, DONE. All outputs are registered.
- IDLE:
  - `Active`, `Operand_valid`, `Busy` and `Done` are 0; `Addr` is 0.
  - `Start` = 1 → CLEAR, with the clear counter loaded to `CLR_CYC`−1.
- CLEAR:
  - `Active` = 0 and `Busy` = 1.
  - Counts down; at 0 → RUN, with run counter `c` = 0.
- RUN: `c` increments every cycle. Let T = `RD_LAT` + `N_IN` + `MAC_LAT`.
  - `Addr` = `c` for `c` < `N_IN`; it holds `N_IN`−1 for `c` ≥ `N_IN`. It never wraps.
  - `Operand_valid` = 1 for `c` in [`RD_LAT`, `RD_LAT`+`N_IN`−1].
  - `Active` = 1 for `c` in [`RD_LAT`, T−1]. The trailing `MAC_LAT` cycles drain the pipeline with zero operands, so the final `Z` includes every term.
  - When `c` = T → DONE.
- DONE:
  - `Done` = 1 and `Busy` = 1 for one cycle; `Active` = 0.
  - Next state is IDLE unconditionally. `Start` is not accepted in DONE.
- `Start` in any state except IDLE is ignored, with no queueing.
- `Abort`:
  - Takes priority over every transition. Next cycle the block is in IDLE with all outputs at idle values, and no `Done` pulse is produced.
  - `Abort` and `Start` together in IDLE: stay in IDLE.
  - `Abort` in DONE: `Done` still completes its single cycle, since it is already registered.
- Counter widths: `c` must hold T without overflow, i.e. `$clog2(T+1)` bits. No arithmetic saturates; ranges are exact by construction.
- `Reset_n` low, at any time including mid-RUN:
  - All outputs go to 0 immediately, asynchronously, and the state goes to IDLE.
  - On release, the first `Start` is accepted on the first rising edge where `Reset_n` is high.

## Timing
- `Start` sampled at edge E0 → `Busy` is high from cycle E0+1.
- CLEAR occupies cycles E0+1 … E0+`CLR_CYC`.
- RUN begins at E0+`CLR_CYC`+1, with the first `Addr` = 0 in that cycle.
- `Done` is high in cycle E0 + `CLR_CYC` + T + 1. With defaults: 2+1+784+2+1 = 790 cycles after E0.
- Back-to-back: `Start` held high is re-accepted in the first IDLE cycle after DONE, so there is 1 idle cycle between runs. `Active` stays low ≥ `CLR_CYC`+2 cycles between runs.
- Throughput: one MAC term per cycle per neuron; no stalls.

## Test plan
- **Reset values:** assert `Reset_n` = 0 mid-RUN with `N_IN`=784 → same cycle, all outputs 0. After release, no activity until `Start`.
- **Nominal small run:** `N_IN`=4, `RD_LAT`=1, `MAC_LAT`=2, `CLR_CYC`=2; pulse `Start` at E0 →
  - `Addr` 0,1,2,3,3,3,3 across E0+3…E0+9;
  - `Operand_valid` high E0+4…E0+7;
  - `Active` high E0+4…E0+9;
  - `Done` at E0+10 only;
  - `Busy` high E0+1…E0+10.
- **End-to-end with neurons:** 3 neuron instances, X=W=16'h2000 (1.0 in Q13), `N_IN`=4 → every `Z` = 16'h8000 (4.0) at `Done`, held afterwards.
- **Ignored Start:** `Start` pulses during CLEAR, RUN and DONE → exactly one `Done`, with timing identical to the nominal run.
- **Abort:** `Abort` at RUN `c`=2 → next cycle IDLE, `Active`=0, no `Done`. A new `Start` then yields a correct `Z`, proving the accumulators were cleared.
- **Back-to-back:** `Start` held high for 3 runs → `Done` at E0+10, E0+21 and E0+32 with defaults-small parameters. `Active` is low for ≥ 4 cycles between runs.

Source files
------------

// File: rtl/layer_sequencer.sv
// Sequencing controller for one fully-connected layer: walks the shared X/W address,
// drives the common neuron Active strobe, gates operands and pulses Done when Z is final.
module layer_sequencer #(
  parameter int unsigned N_IN    = 784,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned CLR_CYC = 2,
  parameter int unsigned AW      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Abort,
  output logic [AW-1:0] Addr,
  output logic          Operand_valid,
  output logic          Active,
  output logic          Busy,
  output logic          Done
);

  localparam int unsigned T  = RD_LAT + N_IN + MAC_LAT;
  localparam int unsigned CW = (T > 0) ? $clog2(T + 1) : 1;
  localparam int unsigned KW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  localparam logic [CW-1:0] C_LAST     = CW'(T - 1);
  localparam logic [CW-1:0] C_OV_LO    = CW'(RD_LAT);
  localparam logic [CW-1:0] C_OV_HI    = CW'(RD_LAT + N_IN - 1);
  localparam logic [CW-1:0] C_ADDR_MAX = CW'(N_IN - 1);
  localparam logic [KW-1:0] K_LOAD     = KW'(CLR_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_clr, w_clr_nxt;
  logic [CW-1:0] r_c, w_c_nxt;

  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_ov, w_ov_nxt;
  logic          r_act, w_act_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;

  // Outputs are decoded from the next state/count so every output is a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr;
    w_c_nxt     = r_c;
    w_addr_nxt  = '0;
    w_ov_nxt    = 1'b0;
    w_act_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = S_CLEAR;
          w_clr_nxt   = K_LOAD;
        end
      end
      S_CLEAR: begin
        if (r_clr == '0) begin
          w_state_nxt = S_RUN;
          w_c_nxt     = '0;
        end else begin
          w_clr_nxt = r_clr - KW'(1);
        end
      end
      S_RUN: begin
        // Leaving at T-1 puts the Done cycle where the count would read T.
        if (r_c == C_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_c_nxt = r_c + CW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (Abort) begin
      w_state_nxt = S_IDLE;
    end

    case (w_state_nxt)
      S_CLEAR: w_busy_nxt = 1'b1;
      S_RUN: begin
        w_busy_nxt = 1'b1;
        w_addr_nxt = (w_c_nxt > C_ADDR_MAX) ? AW'(C_ADDR_MAX) : AW'(w_c_nxt);
        w_ov_nxt   = (w_c_nxt >= C_OV_LO) && (w_c_nxt <= C_OV_HI);
        w_act_nxt  = (w_c_nxt >= C_OV_LO);
      end
      S_DONE: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b1;
        w_addr_nxt = AW'(C_ADDR_MAX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_clr   <= '0;
      r_c     <= '0;
      r_addr  <= '0;
      r_ov    <= 1'b0;
      r_act   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clr   <= w_clr_nxt;
      r_c     <= w_c_nxt;
      r_addr  <= w_addr_nxt;
      r_ov    <= w_ov_nxt;
      r_act   <= w_act_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign Addr          = r_addr;
  assign Operand_valid = r_ov;
  assign Active        = r_act;
  assign Busy          = r_busy;
  assign Done          = r_done;

endmodule
